// File: rtl/sva_stim_pkg.sv
// Shared types and helpers for the implication stimulus generator.
package sva_stim_pkg;

    // Per-run trace flavour; each gives the downstream checker a known outcome.
    typedef enum logic [1:0] {
        OVERLAP   = 2'd0,
        DELAYED   = 2'd1,
        DROP_LAST = 2'd2,
        VACUOUS   = 2'd3
    } stim_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GAP    = 3'd1,
        ST_FIRE   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Saturate a requested distance to the largest supported one.
    function automatic int unsigned clamp_delay(input int unsigned in_val,
                                                input int unsigned max_val);
        return (in_val > max_val) ? max_val : in_val;
    endfunction

endpackage

// File: rtl/stim_down_counter.sv
// Loadable down-counter with terminal-count flag; used as GAP and WAIT timer.
module stim_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    // Load wins over decrement; the owner only enables while count is nonzero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count - W'(1);
    end

    assign tc = (count == '0);

endmodule

// File: rtl/implication_stimulus_gen.sv
// Scripted antecedent/consequent source for the implication-checking stage.
// All outputs are flops loaded from the next-state logic, so no input reaches
// an output combinationally.
module implication_stimulus_gen
    import sva_stim_pkg::*;
#(
    parameter int NUM_PULSES = 8,
    parameter int MAX_DELAY  = 4,
    parameter int GAP        = 2,
    localparam int DW = $clog2(MAX_DELAY + 1),
    localparam int CW = $clog2(NUM_PULSES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  stim_mode_e    mode,
    input  logic [DW-1:0] delay,
    output logic          antecedent,
    output logic          consequent,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pulse_cnt
);

    localparam int GW = $clog2(GAP + 1);
    localparam logic [CW-1:0] LAST     = CW'(NUM_PULSES);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    state_e        state, state_n;
    stim_mode_e    mode_q, mode_n;
    logic [DW-1:0] dist_q, dist_n;
    logic          ant_n, con_n, busy_n, done_n;
    logic [CW-1:0] cnt_n;
    logic          slot_end;
    logic          cur_last, next_last;

    logic          gap_load, gap_en, gap_tc;
    logic [GW-1:0] gap_count;
    logic          wait_load, wait_en, wait_tc;
    logic [DW-1:0] wait_count;

    stim_down_counter #(.W(GW)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .en       (gap_en),
        .count    (gap_count),
        .tc       (gap_tc)
    );

    // WAIT timer holds d-1 on entry so its terminal count marks the consequent slot.
    stim_down_counter #(.W(DW)) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .load_val (dist_q - DW'(1)),
        .en       (wait_en),
        .count    (wait_count),
        .tc       (wait_tc)
    );

    // cur_last: the pulse now in flight is the final one of the run.
    assign cur_last  = (pulse_cnt == LAST);
    assign next_last = ((pulse_cnt + CW'(1)) == LAST);

    // Next state and next registered output values; abort overrides everything.
    always_comb begin
        state_n   = state;
        mode_n    = mode_q;
        dist_n    = dist_q;
        ant_n     = 1'b0;
        con_n     = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        cnt_n     = pulse_cnt;
        gap_load  = 1'b0;
        gap_en    = 1'b0;
        wait_load = 1'b0;
        wait_en   = 1'b0;
        slot_end  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    mode_n   = mode;
                    dist_n   = (mode == DELAYED || mode == DROP_LAST)
                               ? DW'(clamp_delay(32'(delay), MAX_DELAY)) : '0;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    gap_load = 1'b1;
                    state_n  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_tc) begin
                    state_n = ST_FIRE;
                    cnt_n   = pulse_cnt + CW'(1);
                    ant_n   = (mode_q != VACUOUS);
                    con_n   = (dist_q == '0) && (mode_q != VACUOUS)
                              && !(mode_q == DROP_LAST && next_last);
                end else begin
                    gap_en = (gap_count != '0);
                end
            end
            ST_FIRE: begin
                if (dist_q == '0) begin
                    slot_end = 1'b1;
                end else begin
                    state_n   = ST_WAIT;
                    wait_load = 1'b1;
                    con_n     = (dist_q == DW'(1))
                                && !(mode_q == DROP_LAST && cur_last);
                end
            end
            ST_WAIT: begin
                if (wait_tc) begin
                    slot_end = 1'b1;
                end else begin
                    wait_en = (wait_count != '0);
                    con_n   = (wait_count == DW'(1))
                              && !(mode_q == DROP_LAST && cur_last);
                end
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase

        if (slot_end) begin
            if (cur_last) begin
                state_n = ST_FINISH;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end else begin
                state_n  = ST_GAP;
                gap_load = 1'b1;
            end
        end

        if (abort && state != ST_IDLE) begin
            state_n   = ST_IDLE;
            ant_n     = 1'b0;
            con_n     = 1'b0;
            busy_n    = 1'b0;
            done_n    = 1'b0;
            cnt_n     = pulse_cnt;
            gap_load  = 1'b0;
            gap_en    = 1'b0;
            wait_load = 1'b0;
            wait_en   = 1'b0;
        end
    end

    // State, latched run settings and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= OVERLAP;
            dist_q     <= '0;
            antecedent <= 1'b0;
            consequent <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pulse_cnt  <= '0;
        end else begin
            state      <= state_n;
            mode_q     <= mode_n;
            dist_q     <= dist_n;
            antecedent <= ant_n;
            consequent <= con_n;
            busy       <= busy_n;
            done       <= done_n;
            pulse_cnt  <= cnt_n;
        end
    end

endmodule

// File: tb/tb_implication_stimulus_gen.sv
// Bench for implication_stimulus_gen: directed and random runs compared
// cycle by cycle against a pulse-schedule model.
module tb_implication_stimulus_gen;
    import sva_stim_pkg::*;

    localparam int NP = 8;
    localparam int MD = 4;
    localparam int GP = 2;
    localparam int DW = $clog2(MD + 1);
    localparam int CW = $clog2(NP + 1);

    logic          clk = 1'b0;
    logic          rst, start, abort;
    stim_mode_e    mode;
    logic [DW-1:0] delay;
    logic          antecedent, consequent, busy, done;
    logic [CW-1:0] pulse_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic a;
        logic c;
        logic b;
        logic dn;
        int   cnt;
    } exp_t;

    implication_stimulus_gen #(.NUM_PULSES(NP), .MAX_DELAY(MD), .GAP(GP)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .delay      (delay),
        .antecedent (antecedent),
        .consequent (consequent),
        .busy       (busy),
        .done       (done),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_dist(input stim_mode_e m, input int dly);
        if (m == DELAYED || m == DROP_LAST) return (dly > MD) ? MD : dly;
        return 0;
    endfunction

    // Expected outputs c cycles after the start edge, from the pulse schedule.
    function automatic exp_t ref_at(input stim_mode_e m, input int d, input int c);
        exp_t e;
        int p, len, a;
        p   = GP + 1 + d;
        len = NP * p + 1;
        e   = '{a: 1'b0, c: 1'b0, b: 1'b0, dn: 1'b0, cnt: 0};
        for (int k = 0; k < NP; k++) begin
            a = GP + 1 + k * p;
            if (c == a && m != VACUOUS) e.a = 1'b1;
            if (c == a + d && m != VACUOUS && !(m == DROP_LAST && k == NP - 1)) e.c = 1'b1;
            if (c >= a) e.cnt++;
        end
        e.b  = (c >= 1 && c < len);
        e.dn = (c == len);
        return e;
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        chk({tag, " antecedent"}, 32'(antecedent), 32'(e.a));
        chk({tag, " consequent"}, 32'(consequent), 32'(e.c));
        chk({tag, " busy"},       32'(busy),       32'(e.b));
        chk({tag, " done"},       32'(done),       32'(e.dn));
        chk({tag, " pulse_cnt"},  32'(pulse_cnt),  32'(e.cnt));
    endtask

    // One run: start at a negedge, then compare every following cycle.
    // abort_c>0 raises abort during that cycle; noisy wiggles start/mode/delay mid-run.
    task automatic run(input stim_mode_e m, input int dly, input int abort_c,
                       input bit abort_with_start, input bit noisy, input int extra);
        exp_t e;
        int   d, len, held;
        d    = eff_dist(m, dly);
        len  = NP * (GP + 1 + d) + 1;
        held = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        delay = dly[DW-1:0];
        abort = abort_with_start;
        for (int c = 1; c <= len + extra; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (abort_c > 0 && c > abort_c)
                e = '{a: 1'b0, c: 1'b0, b: 1'b0, dn: 1'b0, cnt: held};
            else
                e = ref_at(m, d, c);
            check_outs($sformatf("m%0d d%0d c%0d", m, dly, c), e);
            if (c == abort_c) begin
                held  = e.cnt;
                abort = 1'b1;
            end
            if (noisy && c < len) begin
                start = 1'($urandom_range(0, 1));
                mode  = stim_mode_e'($urandom_range(0, 3));
                delay = DW'($urandom_range(0, 7));
            end
        end
    endtask

    initial begin
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = OVERLAP;
        delay = '0;
        repeat (2) @(negedge clk);
        e = '{a: 1'b0, c: 1'b0, b: 1'b0, dn: 1'b0, cnt: 0};
        check_outs("reset", e);
        rst = 1'b0;

        run(OVERLAP,   0, 0,  1'b0, 1'b0, 3);
        run(DELAYED,   3, 0,  1'b0, 1'b1, 3);
        run(DROP_LAST, 0, 0,  1'b0, 1'b0, 3);
        run(VACUOUS,   5, 0,  1'b1, 1'b0, 3);
        run(DROP_LAST, 4, 0,  1'b0, 1'b0, 2);
        // delay=7 saturates to 4; third WAIT spans cycles 18..21
        run(DELAYED,   7, 19, 1'b0, 1'b0, 4);

        // Asynchronous reset in the first WAIT of a DELAYED run.
        @(negedge clk);
        start = 1'b1;
        mode  = DELAYED;
        delay = DW'(3);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_outs($sformatf("prerst c%0d", c), ref_at(DELAYED, 3, c));
        end
        #1 rst = 1'b1;
        #1;
        e = '{a: 1'b0, c: 1'b0, b: 1'b0, dn: 1'b0, cnt: 0};
        check_outs("midrun rst", e);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outs("after rst", e);
        run(DELAYED, 2, 0, 1'b0, 1'b0, 2);

        repeat (6) begin
            run(stim_mode_e'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 0, 1'b0, 1'b1, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/implication_stimulus_gen.md
Name: implication_stimulus_gen

Overview:
- Scripted stimulus source that drives the antecedent/consequent pair into the implication-checking stage directly downstream.
- Produces deterministic, non-overlapping antecedent pulses, each followed by a consequent pulse at a programmable distance.
- Per-run modes give passing, failing and vacuous traces, so the downstream assert and cover directives each have a known outcome.
- Lets the checker stage run formally or in simulation without hand-forced assigns.

Parameters:
- NUM_PULSES, 8: antecedent pulses per run (>=1).
- MAX_DELAY, 4: largest antecedent-to-consequent distance in cycles.
- GAP, 2: idle cycles between a consequent and the next antecedent (>=1).

Ports:
- clk  in  1  sole clock, posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  synchronous cancel of a run in progress.
- mode  in  2  stim_mode_e: OVERLAP, DELAYED, DROP_LAST, VACUOUS.
- delay  in  $clog2(MAX_DELAY+1)  consequent distance for DELAYED and DROP_LAST.
- antecedent  out  1  to checker stage.
- consequent  out  1  to checker stage.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at normal run end.
- pulse_cnt  out  $clog2(NUM_PULSES+1)  antecedent pulses issued this run.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. This takes effect immediately on rst, including mid-run; no done is issued.
- Outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, GAP, FIRE, WAIT, FINISH.
- IDLE: start=1 latches mode and delay; delay > MAX_DELAY saturates to MAX_DELAY. Go to GAP and assert busy next cycle. start is ignored in every other state.
- GAP: hold for GAP cycles with antecedent=consequent=0, then go to FIRE.
- FIRE: one cycle.
  - antecedent=1, except in VACUOUS, where it stays 0.
  - pulse_cnt increments on the FIRE cycle; VACUOUS still counts.
  - Effective distance d: 0 for OVERLAP and VACUOUS; latched delay for DELAYED and DROP_LAST.
  - If d=0, consequent=1 in the same cycle as antecedent.
  - If d>0, go to WAIT.
- WAIT: count d cycles. consequent=1 for exactly one cycle, d cycles after FIRE.
- Consequent suppression:
  - DROP_LAST: on the pulse where pulse_cnt becomes NUM_PULSES, consequent stays 0 (forced checker failure), even if d=0.
  - VACUOUS: consequent is always 0.
- After the consequent slot:
  - If pulse_cnt < NUM_PULSES, go to GAP.
  - Otherwise go to FINISH.
- FINISH: one cycle. done=1 and busy=0, then IDLE. pulse_cnt holds its value until the next start.
- Timing with start sampled at edge t0:
  - First antecedent occupies cycle t0+GAP+1.
  - Pulse k at cycle a_k: consequent at a_k+d; next antecedent at a_k+d+GAP+1.
  - done at a_last+d+1.
  - Total run length NUM_PULSES*(GAP+1+d)+1 cycles.
- Non-overlap guarantee: at most one antecedent is outstanding, and consequent is never high outside its slot.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, all outputs 0, no done, pulse_cnt holds.
  - abort takes priority over every transition.
  - In IDLE, abort is ignored; if start and abort are both 1 in IDLE, start wins.
- Boundary cases:
  - delay=MAX_DELAY: WAIT counter reaches terminal count without wrap.
  - NUM_PULSES=1 with DROP_LAST: the only pulse fails.

Decomposition:
- Package sva_stim_pkg holds:
  - stim_mode_e (2-bit enum: OVERLAP=0, DELAYED=1, DROP_LAST=2, VACUOUS=3).
  - state_e.
  - Function clamp_delay(in, max).
- One natural sub-module: stim_down_counter, a loadable down-counter with terminal-count flag.
  - Instantiated twice: GAP timer and WAIT timer.
- pulse_cnt stays inline.

Test Plan:
- rst then start, mode=OVERLAP, defaults -> antecedent and consequent coincide at t0+3, t0+6, ... (8 pulses); done at t0+25; pulse_cnt=8.
- start, mode=DELAYED, delay=3 -> consequent exactly 3 cycles after each antecedent; first antecedent t0+3, consequent t0+6; done at t0+49.
- start, mode=DROP_LAST, delay=0 -> pulses 1-7 have consequent; pulse 8 has antecedent only. Downstream assert fails once, at that cycle.
- start, mode=VACUOUS -> antecedent and consequent stay 0 throughout; busy high 24 cycles; done at t0+25; pulse_cnt=8.
- start, delay=7 with MAX_DELAY=4 -> d saturates to 4. abort during third WAIT -> IDLE next cycle, outputs 0, no done, pulse_cnt=3.
- rst asserted in WAIT while busy=1 -> outputs 0 immediately, before the next edge. A subsequent start runs a full clean sequence.
